// File: rtl/regfile.sv
// 32 x 64-bit register file: one synchronous write port, two combinational read ports.
// The register at ZERO_REG is hardwired to zero; writes to it are discarded.
module regfile #(
    parameter int WIDTH    = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [WIDTH-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0] wr_en_s;

    // One-hot load enables; the zero register never receives an enable.
    function automatic logic [DEPTH-1:0] decode_onehot(
        input logic [ADDR_W-1:0] idx,
        input logic              en
    );
        logic [DEPTH-1:0] oh;
        oh = '0;
        if (en && (idx != ZERO_IDX)) begin
            oh[idx] = 1'b1;
        end else begin
            oh = '0;
        end
        return oh;
    endfunction

    // Write-address decode gated by RegWrite
    always_comb begin
        wr_en_s = decode_onehot(WriteRegister, RegWrite);
    end

    // Register storage; reset takes priority over a same-cycle write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en_s[i]) begin
                    regs_r[i] <= WriteData;
                end
            end
        end
    end

    // Read muxes with no write bypass; the zero register reads 0 even before the first reset
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (ReadRegister1 == ZERO_IDX) begin
            ReadData1 = '0;
        end else begin
            ReadData1 = regs_r[ReadRegister1];
        end
        if (ReadRegister2 == ZERO_IDX) begin
            ReadData2 = '0;
        end else begin
            ReadData2 = regs_r[ReadRegister2];
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: reset, write/readback, zero register,
// write disable, read-during-write and reset-versus-write priority.
module tb_regfile;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    regfile dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks_cnt++;
        if (actual !== expected) begin
            failures_cnt++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Advance one rising edge, then move off the edge before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [63:0] data);
        RegWrite      = 1'b1;
        WriteRegister = idx;
        WriteData     = data;
        tick();
        RegWrite      = 1'b0;
    endtask

    task automatic read_both(input logic [4:0] idx1, input logic [4:0] idx2);
        ReadRegister1 = idx1;
        ReadRegister2 = idx2;
        #1;
    endtask

    initial begin
        logic [63:0] pat;
        pat           = 64'h0101_0101_0101_0101;
        reset         = 1'b0;
        RegWrite      = 1'b0;
        WriteRegister = 5'd0;
        WriteData     = 64'h0;
        ReadRegister1 = 5'd31;
        ReadRegister2 = 5'd31;
        #2;
        check_eq("zero_before_reset_p1", ReadData1, 64'h0);
        check_eq("zero_before_reset_p2", ReadData2, 64'h0);

        // 1: reset clears every register
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_both(5'(i), 5'(31 - i));
            check_eq($sformatf("reset_p1_r%0d", i), ReadData1, 64'h0);
            check_eq($sformatf("reset_p2_r%0d", 31 - i), ReadData2, 64'h0);
        end

        // 2: write each register with a distinct value, then read all back
        for (int i = 0; i < 31; i++) begin
            write_reg(5'(i), 64'(i) * pat);
        end
        for (int i = 0; i < 32; i++) begin
            read_both(5'(i), 5'(i));
            check_eq($sformatf("wr_p1_r%0d", i), ReadData1, (i == 31) ? 64'h0 : 64'(i) * pat);
            check_eq($sformatf("wr_p2_r%0d", i), ReadData2, (i == 31) ? 64'h0 : 64'(i) * pat);
        end

        // 3: writes to the zero register are discarded
        write_reg(5'd31, 64'hDEAD_BEEF_DEAD_BEEF);
        read_both(5'd31, 5'd30);
        check_eq("xzr_p1", ReadData1, 64'h0);
        check_eq("xzr_neighbour_p2", ReadData2, 64'h1E1E_1E1E_1E1E_1E1E);

        // 4: RegWrite=0 leaves the register untouched
        write_reg(5'd5, 64'h5555);
        RegWrite      = 1'b0;
        WriteRegister = 5'd5;
        WriteData     = 64'hFFFF;
        tick();
        read_both(5'd5, 5'd6);
        check_eq("wdis_r5", ReadData1, 64'h5555);
        check_eq("wdis_r6", ReadData2, 64'h0606_0606_0606_0606);

        // 5: read-during-write returns the old value until the edge
        write_reg(5'd7, 64'hAAAA);
        read_both(5'd7, 5'd7);
        RegWrite      = 1'b1;
        WriteRegister = 5'd7;
        WriteData     = 64'hBBBB;
        #1;
        check_eq("rdw_before_p1", ReadData1, 64'hAAAA);
        check_eq("rdw_before_p2", ReadData2, 64'hAAAA);
        tick();
        RegWrite = 1'b0;
        check_eq("rdw_after_p1", ReadData1, 64'hBBBB);
        check_eq("rdw_after_p2", ReadData2, 64'hBBBB);

        // 6: reset wins over a simultaneous write; writes resume afterwards
        write_reg(5'd3, 64'h1234);
        read_both(5'd3, 5'd7);
        check_eq("rst_pre_r3", ReadData1, 64'h1234);
        reset         = 1'b1;
        RegWrite      = 1'b1;
        WriteRegister = 5'd3;
        WriteData     = 64'hCAFE;
        tick();
        reset    = 1'b0;
        RegWrite = 1'b0;
        read_both(5'd3, 5'd7);
        check_eq("rst_beats_wr_r3", ReadData1, 64'h0);
        check_eq("rst_clears_r7", ReadData2, 64'h0);
        write_reg(5'd3, 64'hCAFE);
        read_both(5'd3, 5'd4);
        check_eq("post_rst_wr_r3", ReadData1, 64'hCAFE);
        check_eq("post_rst_r4", ReadData2, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32-entry × 64-bit register file for the single-cycle datapath.
- It is the storage stage fed by the write-address decode tree: the 5-bit write address plus RegWrite become 32 one-hot register enables.
- It has two combinational read ports and one synchronous write port.
- Register 31 is hardwired to zero (XZR).

Parameters:
- WIDTH, 64, data width of each register.
- ADDR_W, 5, register address width; depth = 2**ADDR_W = 32.
- ZERO_REG, 31, index of the hardwired-zero register.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; clears all registers.
- RegWrite  input  1  write enable for the current cycle.
- WriteRegister  input  ADDR_W  destination register index.
- WriteData  input  WIDTH  data written on the rising edge when RegWrite=1.
- ReadRegister1  input  ADDR_W  read port 1 index.
- ReadRegister2  input  ADDR_W  read port 2 index.
- ReadData1  output  WIDTH  contents of ReadRegister1 (combinational).
- ReadData2  output  WIDTH  contents of ReadRegister2 (combinational).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Storage: 32 WIDTH-bit registers, each a bank of edge-triggered D flip-flops with a per-register load enable.
- Write decode:
  - WriteRegister is decoded to 32 one-hot enables, gated by RegWrite.
  - RegWrite=0 forces all enables low.
  - At most one enable is high in any cycle.
- Write timing:
  - On a rising edge with reset=0, RegWrite=1 and WriteRegister!=ZERO_REG, register[WriteRegister] <= WriteData.
  - All other registers hold their value.
- Write latency: 1 edge. The new value appears on a read port after the edge that captures it, never in the same cycle.
- Read-during-write, same address, same cycle: ReadData returns the OLD value until the edge. There is no bypass; forwarding belongs to the pipeline.
- Read ports:
  - Purely combinational 32:1 muxes, one WIDTH-bit mux per port, on register contents.
  - Both ports are independent; both may address the same register.
- Zero register:
  - Writes to ZERO_REG are discarded (enable suppressed).
  - Reads of ZERO_REG always return 0, including after a write attempt.
- Reset:
  - On a rising edge with reset=1, every register is cleared to 0.
  - Reset has priority over a simultaneous write.
  - After the reset edge, ReadData1 and ReadData2 read 0 for every address.
  - Before the first reset edge, register contents are X (except ZERO_REG reads 0).
- Reset mid-operation: a write presented in the same cycle as reset is lost. Writes resume on the first edge with reset=0.
- Address width: indices are exactly ADDR_W bits, so no out-of-range addresses exist.

Test Plan:
1. Reset clears all registers: hold reset=1 for one edge, then reset=0; sweep ReadRegister1/2 over 0..31 → ReadData1 and ReadData2 read 64'h0 at every index.
2. Write then read back: for i=0..30, write WriteData = i*64'h0101_0101_0101_0101 with RegWrite=1, one edge each; then read all 31 indices on both ports → each returns its written value, and no other register is disturbed.
3. Zero register: RegWrite=1, WriteRegister=31, WriteData=64'hDEAD_BEEF_DEAD_BEEF, one edge → ReadData1 at ReadRegister1=31 reads 64'h0.
4. Write disabled: R5 holds 64'h5555; apply RegWrite=0, WriteRegister=5, WriteData=64'hFFFF, one edge → R5 still reads 64'h5555.
5. Read-during-write: R7 holds 64'hAAAA; ReadRegister1=ReadRegister2=7, RegWrite=1, WriteData=64'hBBBB → both ports read 64'hAAAA before the edge and 64'hBBBB after it.
6. Reset beats write: R3 holds 64'h1234; assert reset=1 with RegWrite=1, WriteRegister=3, WriteData=64'hCAFE, one edge → R3 reads 64'h0; after reset drops, the next write edge of 64'hCAFE sets R3 to 64'hCAFE.
